// File: rtl/reg_piso_tx.sv
// Parallel-in serial-out transmitter with a valid/ready load handshake.
// A word is loaded into a shift register, then sent one bit per enabled clock.
// A new word can be taken on the same edge as the last bit, so words follow each other with no gap.
module reg_piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             done_q, done_d;

  logic             last_bit;
  logic             consume;
  logic             load_fire;
  logic [WIDTH-1:0] shifted;

  // In SHIFT a word is accepted only on the edge that consumes its last bit.
  // This keeps a stalled last bit from being overwritten.
  always_comb begin
    last_bit  = (state_q == SHIFT) && (bit_cnt_q == '0);
    consume   = (state_q == SHIFT) && shift_en;
    load_fire = load_valid && ((state_q == IDLE) || (last_bit && shift_en));
    shifted   = MSB_FIRST ? {shift_reg_q[WIDTH-2:0], 1'b0}
                          : {1'b0, shift_reg_q[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_reg_q <= '0;
      bit_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      bit_cnt_q   <= bit_cnt_d;
      done_q      <= done_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    bit_cnt_d   = bit_cnt_q;
    done_d      = consume && last_bit;
    if (load_fire) begin
      state_d     = SHIFT;
      shift_reg_d = a;
      bit_cnt_d   = CNT_TOP;
    end else if (consume) begin
      shift_reg_d = shifted;
      if (last_bit) begin
        state_d = IDLE;
      end else begin
        bit_cnt_d = bit_cnt_q - CW'(1);
      end
    end
  end

  always_comb begin
    load_ready = (state_q == IDLE) || last_bit;
    busy       = (state_q == SHIFT);
    sdo_valid  = busy;
    frame      = busy && (bit_cnt_q == CNT_TOP);
    sdo        = 1'b0;
    if (busy) begin
      sdo = MSB_FIRST ? shift_reg_q[WIDTH-1] : shift_reg_q[0];
    end
    done = done_q;
  end

endmodule

// File: tb/tb_reg_piso_tx.sv
// Self-checking bench for reg_piso_tx. It runs an MSB-first copy and an LSB-first copy side by side.
// Both copies are compared each cycle against a word/bits-remaining reference model.
module tb_reg_piso_tx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] a = '0;
  logic         load_valid = 1'b0;
  logic         shift_en = 1'b0;

  logic load_ready_m, sdo_m, sdo_valid_m, frame_m, busy_m, done_m;
  logic load_ready_l, sdo_l, sdo_valid_l, frame_l, busy_l, done_l;

  int checks = 0;
  int errors = 0;

  // Reference model: the word in flight and how many of its bits are still unsent.
  int           rem = 0;
  logic [W-1:0] word = '0;
  logic         done_exp = 1'b0;

  logic q_m[$];
  logic q_l[$];
  logic fq[$];
  int   done_cnt = 0;

  always #5 clk = ~clk;

  reg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .a(a), .load_valid(load_valid), .load_ready(load_ready_m),
    .shift_en(shift_en), .sdo(sdo_m), .sdo_valid(sdo_valid_m), .frame(frame_m),
    .busy(busy_m), .done(done_m)
  );

  reg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .a(a), .load_valid(load_valid), .load_ready(load_ready_l),
    .shift_en(shift_en), .sdo(sdo_l), .sdo_valid(sdo_valid_l), .frame(frame_l),
    .busy(busy_l), .done(done_l)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    rem      = 0;
    word     = '0;
    done_exp = 1'b0;
  endtask

  task automatic clear_logs();
    q_m.delete();
    q_l.delete();
    fq.delete();
    done_cnt = 0;
  endtask

  // One clock cycle, entered just after a falling edge.
  // Drive inputs, compare both DUTs against the model, then advance the model across the rising edge.
  task automatic step(input logic lv, input logic [W-1:0] av, input logic se, input string tag);
    logic exp_valid, exp_frame, exp_ready, exp_sdo_m, exp_sdo_l, fire, cons;
    int   idx;
    load_valid = lv;
    a          = av;
    shift_en   = se;
    #1;
    exp_valid = (rem > 0);
    exp_frame = (rem == W);
    exp_ready = (rem <= 1);
    exp_sdo_m = 1'b0;
    exp_sdo_l = 1'b0;
    if (rem > 0) begin
      idx       = W - rem;
      exp_sdo_m = word[W-1-idx];
      exp_sdo_l = word[idx];
    end
    checks += 12;
    if (sdo_m !== exp_sdo_m) begin errors++; $display("FAIL %s sdo_m: got %b expected %b", tag, sdo_m, exp_sdo_m); end
    if (sdo_l !== exp_sdo_l) begin errors++; $display("FAIL %s sdo_l: got %b expected %b", tag, sdo_l, exp_sdo_l); end
    if (sdo_valid_m !== exp_valid) begin errors++; $display("FAIL %s sdo_valid_m: got %b expected %b", tag, sdo_valid_m, exp_valid); end
    if (sdo_valid_l !== exp_valid) begin errors++; $display("FAIL %s sdo_valid_l: got %b expected %b", tag, sdo_valid_l, exp_valid); end
    if (busy_m !== exp_valid) begin errors++; $display("FAIL %s busy_m: got %b expected %b", tag, busy_m, exp_valid); end
    if (busy_l !== exp_valid) begin errors++; $display("FAIL %s busy_l: got %b expected %b", tag, busy_l, exp_valid); end
    if (frame_m !== exp_frame) begin errors++; $display("FAIL %s frame_m: got %b expected %b", tag, frame_m, exp_frame); end
    if (frame_l !== exp_frame) begin errors++; $display("FAIL %s frame_l: got %b expected %b", tag, frame_l, exp_frame); end
    if (load_ready_m !== exp_ready) begin errors++; $display("FAIL %s load_ready_m: got %b expected %b", tag, load_ready_m, exp_ready); end
    if (load_ready_l !== exp_ready) begin errors++; $display("FAIL %s load_ready_l: got %b expected %b", tag, load_ready_l, exp_ready); end
    if (done_m !== done_exp) begin errors++; $display("FAIL %s done_m: got %b expected %b", tag, done_m, done_exp); end
    if (done_l !== done_exp) begin errors++; $display("FAIL %s done_l: got %b expected %b", tag, done_l, done_exp); end
    if (done_m) done_cnt++;
    if (sdo_valid_m && se) begin
      q_m.push_back(sdo_m);
      q_l.push_back(sdo_l);
      fq.push_back(frame_m);
    end
    fire     = lv && exp_ready && ((rem == 0) || se);
    cons     = (rem > 0) && se;
    done_exp = cons && (rem == 1);
    if (fire) begin
      word = av;
      rem  = W;
    end else if (cons) begin
      rem--;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; load_valid = 1'b1; a = 4'hF; shift_en = 1'b1;
    #1;
    checks += 3;
    if (load_ready_m !== 1'b1) begin errors++; $display("FAIL reset load_ready: got %b expected 1", load_ready_m); end
    if (sdo_valid_m !== 1'b0 || sdo_m !== 1'b0) begin errors++; $display("FAIL reset sdo: got valid=%b sdo=%b expected 0/0", sdo_valid_m, sdo_m); end
    if (busy_m !== 1'b0 || done_m !== 1'b0 || frame_m !== 1'b0) begin errors++; $display("FAIL reset flags: got busy=%b done=%b frame=%b expected 0", busy_m, done_m, frame_m); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy_m !== 1'b0 || sdo_valid_l !== 1'b0) begin errors++; $display("FAIL reset capture: got busy=%b expected 0", busy_m); end
    @(negedge clk);
    load_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    clear_logs();
    repeat (3) step(1'b0, 4'hF, 1'b1, "reset_idle");
  endtask

  task automatic test_msb_first();
    logic [3:0] exp_bits;
    logic [3:0] exp_frame;
    exp_bits  = 4'b1010;
    exp_frame = 4'b1000;
    clear_logs();
    step(1'b1, 4'b1010, 1'b1, "msb_load");
    repeat (4) step(1'b0, 4'h0, 1'b1, "msb_shift");
    step(1'b0, 4'h0, 1'b1, "msb_done");
    checks++;
    if (q_m.size() != 4) begin
      errors++; $display("FAIL msb_len: got %0d bits expected 4", q_m.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (q_m[i] !== exp_bits[3-i]) begin errors++; $display("FAIL msb_bit%0d: got %b expected %b", i, q_m[i], exp_bits[3-i]); end
        if (fq[i] !== exp_frame[3-i]) begin errors++; $display("FAIL msb_frame%0d: got %b expected %b", i, fq[i], exp_frame[3-i]); end
      end
    end
    checks += 2;
    if (done_cnt != 1) begin errors++; $display("FAIL msb_done_count: got %0d expected 1", done_cnt); end
    if (busy_m !== 1'b0) begin errors++; $display("FAIL msb_idle: got busy=%b expected 0", busy_m); end
  endtask

  task automatic test_lsb_first();
    logic [3:0] exp_bits;
    exp_bits = 4'b1100;
    clear_logs();
    step(1'b1, 4'b0011, 1'b1, "lsb_load");
    repeat (5) step(1'b0, 4'h0, 1'b1, "lsb_shift");
    checks++;
    if (q_l.size() != 4) begin
      errors++; $display("FAIL lsb_len: got %0d bits expected 4", q_l.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_l[i] !== exp_bits[3-i]) begin errors++; $display("FAIL lsb_bit%0d: got %b expected %b", i, q_l[i], exp_bits[3-i]); end
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL lsb_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bits;
    int         frames;
    exp_bits = 8'b0011_1111;
    frames   = 0;
    clear_logs();
    step(1'b1, 4'b0011, 1'b1, "b2b_load");
    repeat (4) step(1'b1, 4'b1111, 1'b1, "b2b_first");
    repeat (4) step(1'b0, 4'h0, 1'b1, "b2b_second");
    repeat (2) step(1'b0, 4'h0, 1'b1, "b2b_tail");
    checks++;
    if (q_m.size() != 8) begin
      errors++; $display("FAIL b2b_len: got %0d bits expected 8", q_m.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (q_m[i] !== exp_bits[7-i]) begin errors++; $display("FAIL b2b_bit%0d: got %b expected %b", i, q_m[i], exp_bits[7-i]); end
        if (fq[i] === 1'b1) frames++;
      end
      checks += 2;
      if (fq[0] !== 1'b1 || fq[4] !== 1'b1) begin errors++; $display("FAIL b2b_frame_pos: got %b/%b expected 1/1", fq[0], fq[4]); end
      if (frames != 2) begin errors++; $display("FAIL b2b_frame_count: got %0d expected 2", frames); end
    end
    checks++;
    if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt); end
  endtask

  task automatic test_stall();
    logic [3:0] exp_bits;
    exp_bits = 4'b0101;
    clear_logs();
    step(1'b1, 4'b0101, 1'b1, "stall_load");
    step(1'b0, 4'h0, 1'b1, "stall_bit1");
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      shift_en   = 1'b0;
      #1;
      checks += 2;
      if (sdo_m !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: got sdo=%b expected 1", i, sdo_m); end
      if (load_ready_m !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b expected 0", i, load_ready_m); end
      step(1'b1, 4'hF, 1'b0, "stall_gap");
    end
    repeat (4) step(1'b0, 4'h0, 1'b1, "stall_rest");
    checks++;
    if (q_m.size() != 4) begin
      errors++; $display("FAIL stall_len: got %0d bits expected 4", q_m.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_m[i] !== exp_bits[3-i]) begin errors++; $display("FAIL stall_bit%0d: got %b expected %b", i, q_m[i], exp_bits[3-i]); end
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_last_bit_stall();
    clear_logs();
    step(1'b1, 4'b1001, 1'b1, "lbs_load");
    repeat (3) step(1'b0, 4'h0, 1'b1, "lbs_shift");
    repeat (2) step(1'b1, 4'b0110, 1'b0, "lbs_hold");
    step(1'b1, 4'b0110, 1'b1, "lbs_take");
    repeat (5) step(1'b0, 4'h0, 1'b1, "lbs_second");
    checks++;
    if (done_cnt != 2) begin errors++; $display("FAIL lbs_done_count: got %0d expected 2", done_cnt); end
  endtask

  task automatic test_mid_reset();
    logic [3:0] exp_bits;
    exp_bits = 4'b0110;
    clear_logs();
    step(1'b1, 4'b1100, 1'b1, "mrst_load");
    repeat (2) step(1'b0, 4'h0, 1'b1, "mrst_shift");
    load_valid = 1'b0;
    shift_en   = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks += 3;
    if (sdo_valid_m !== 1'b0 || busy_m !== 1'b0) begin errors++; $display("FAIL mrst_abort: got valid=%b busy=%b expected 0/0", sdo_valid_m, busy_m); end
    if (load_ready_m !== 1'b1 || sdo_m !== 1'b0) begin errors++; $display("FAIL mrst_outputs: got ready=%b sdo=%b expected 1/0", load_ready_m, sdo_m); end
    if (done_m !== 1'b0 || frame_m !== 1'b0) begin errors++; $display("FAIL mrst_flags: got done=%b frame=%b expected 0/0", done_m, frame_m); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    clear_logs();
    repeat (2) step(1'b0, 4'h0, 1'b1, "mrst_idle");
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL mrst_no_done: got %0d pulses expected 0", done_cnt); end
    step(1'b1, 4'b0110, 1'b1, "mrst_reload");
    repeat (5) step(1'b0, 4'h0, 1'b1, "mrst_shift2");
    checks++;
    if (q_m.size() != 4) begin
      errors++; $display("FAIL mrst_len: got %0d bits expected 4", q_m.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_m[i] !== exp_bits[3-i]) begin errors++; $display("FAIL mrst_bit%0d: got %b expected %b", i, q_m[i], exp_bits[3-i]); end
      end
    end
  endtask

  task automatic test_random();
    logic         lv, se;
    logic [W-1:0] av;
    for (int i = 0; i < 600; i++) begin
      lv = 1'($urandom_range(0, 1));
      se = 1'(($urandom % 4) != 0);
      av = W'($urandom);
      step(lv, av, se, "random");
    end
    repeat (W + 2) step(1'b0, '0, 1'b1, "random_drain");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_stall();
    test_last_bit_stall();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
